// File: rtl/output_writer.sv
// Write-back stage: rescales signed accumulator words to Q8.8 (shift, optional ReLU,
// saturation) and writes one frame of DEPTH words to RAM addresses 0..DEPTH-1.
module output_writer #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         relu_en,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [ACC_WIDTH-1:0]  in_data,
    output logic        [ADDR_WIDTH-1:0] ram_address,
    output logic        [DATA_WIDTH-1:0] ram_write_data,
    output logic                         ram_enable,
    output logic                         ram_write,
    output logic                         busy,
    output logic                         done,
    output logic                         sat_flag,
    output logic        [1:0]            dbg_state
);
    // Handshake: a word is consumed on a rising edge where in_valid and in_ready are
    // both high; with in_ready low the upstream holds in_data and in_valid unchanged.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

    state_t                         state;
    logic        [CW-1:0]           count;
    logic signed [ACC_WIDTH-1:0]    shifted;
    logic signed [ACC_WIDTH-1:0]    rectified;
    logic        [DATA_WIDTH-1:0]   word_val;
    logic                           word_sat;
    logic                           accept;
    logic                           last_word;

    assign in_ready  = (state == RUN) && (count < CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign last_word = (count == CW'(DEPTH - 1));
    assign busy      = (state != IDLE);
    assign ram_write = ram_enable;
    assign dbg_state = state;

    // The ReLU clamp happens before saturation so it never raises sat_flag.
    always_comb begin
        shifted   = in_data >>> FRAC_BITS;
        rectified = (relu_en && (shifted < 0)) ? '0 : shifted;
        word_sat  = 1'b0;
        word_val  = rectified[DATA_WIDTH-1:0];
        if (rectified > SAT_MAX) begin
            word_val = SAT_MAX[DATA_WIDTH-1:0];
            word_sat = 1'b1;
        end else if (rectified < SAT_MIN) begin
            word_val = SAT_MIN[DATA_WIDTH-1:0];
            word_sat = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            ram_enable     <= 1'b0;
            ram_address    <= '0;
            ram_write_data <= '0;
            done           <= 1'b0;
            sat_flag       <= 1'b0;
        end else begin
            ram_enable <= accept;
            done       <= accept && last_word;
            if (accept) begin
                ram_address    <= count[ADDR_WIDTH-1:0];
                ram_write_data <= word_val;
                count          <= count + 1'b1;
                if (word_sat) sat_flag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        count    <= '0;
                        sat_flag <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept && last_word) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_writer.sv
// Randomized bench for output_writer: an arithmetic reference model predicts every
// RAM write (cycle, address, data, done) and the frame-level status outputs.
module tb_output_writer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        relu_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  ram_address;
    logic [15:0] ram_write_data;
    logic        ram_enable;
    logic        ram_write;
    logic        busy;
    logic        done;
    logic        sat_flag;
    logic [1:0]  dbg_state;

    output_writer dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .relu_en        (relu_en),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_enable     (ram_enable),
        .ram_write      (ram_write),
        .busy           (busy),
        .done           (done),
        .sat_flag       (sat_flag),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // scoreboard: {done, cycle[15:0], addr[2:0], data[15:0]}
    localparam int W = 36;
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference: floor(v / 2^8), optional ReLU, then clamp to 16-bit signed
    function automatic logic [15:0] ref_word(input logic [31:0] v, input bit relu, output bit sat);
        longint sv;
        longint s;
        sv = longint'($signed(v));
        if (sv >= 0) s = sv / 256;
        else         s = -((-sv + 255) / 256);
        if (relu && s < 0) s = 0;
        sat = 1'b0;
        if (s > 32767)  begin s = 32767;  sat = 1'b1; end
        if (s < -32768) begin s = -32768; sat = 1'b1; end
        return 16'(s);
    endfunction

    always @(negedge clock) begin
        logic [W-1:0] e;
        if (ram_enable === 1'b1 || done === 1'b1) begin
            chk("wr_enable", 32'(ram_enable), 1);
            chk("wr_strobe", 32'(ram_write), 32'(ram_enable));
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_cycle", 32'(cyc[15:0]), 32'(e[34:19]));
                chk("wr_addr", 32'(ram_address), 32'(e[18:16]));
                chk("wr_data", 32'(ram_write_data), 32'(e[15:0]));
                chk("wr_done", 32'(done), 32'(e[35]));
            end
        end
    end

    // driver
    logic [31:0] fdata[8];
    bit          frelu[8];

    task automatic idle_inputs();
        start = 0; relu_en = 0; in_valid = 0; in_data = '0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_en"}, 32'(ram_enable), 0);
        chk({tag, "_wr"}, 32'(ram_write), 0);
        chk({tag, "_addr"}, 32'(ram_address), 0);
        chk({tag, "_data"}, 32'(ram_write_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_sat"}, 32'(sat_flag), 0);
        chk({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    task automatic send_word(input logic [31:0] v, input bit relu, input int idx,
                             input bit noise, output bit sat, output bit ok);
        logic [15:0] w;
        int waitc = 0;
        in_data = v; relu_en = relu; in_valid = 1;
        if (noise) start = 1'($urandom_range(0, 1));
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(posedge clock); #1; waitc++;
        end
        ok = (in_ready === 1'b1);
        sat = 0;
        if (!ok) begin
            chk("ready_timeout", 32'(in_ready), 1);
            return;
        end
        @(posedge clock); #1;
        w = ref_word(v, relu, sat);
        exp_q.push_back({(idx == 7), 16'(cyc), 3'(idx), w});
        start = 0;
    endtask

    task automatic run_frame(input bit throttle, input bit noise);
        bit any_sat = 0;
        bit s, ok;
        start = 1; @(posedge clock); #1; start = 0;
        chk("start_busy", 32'(busy), 1);
        chk("start_ready", 32'(in_ready), 1);
        chk("start_sat_clr", 32'(sat_flag), 0);
        chk("start_state", 32'(dbg_state), 1);
        for (int i = 0; i < 8; i++) begin
            if (throttle) begin
                in_valid = 0;
                repeat ($urandom_range(0, 2)) begin
                    if (noise) start = 1'($urandom_range(0, 1));
                    @(posedge clock); #1;
                end
            end
            send_word(fdata[i], frelu[i], i, noise, s, ok);
            if (!ok) begin
                idle_inputs();
                return;
            end
            any_sat |= s;
        end
        if (!throttle) in_valid = 0;
        chk("done_pulse", 32'(done), 1);
        chk("done_state", 32'(dbg_state), 2);
        chk("done_busy", 32'(busy), 1);
        chk("done_ready", 32'(in_ready), 0);
        chk("done_sat", 32'(sat_flag), 32'(any_sat));
        start = noise;
        @(posedge clock); #1;
        start = 0; in_valid = 0;
        chk("post_busy", 32'(busy), 0);
        chk("post_state", 32'(dbg_state), 0);
        chk("post_ready", 32'(in_ready), 0);
        chk("post_done", 32'(done), 0);
        chk("post_sat_sticky", 32'(sat_flag), 32'(any_sat));
    endtask

    function automatic logic [31:0] rand_acc();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return 32'($urandom_range(0, 32'h00FF_FFFF));
            2:       return -32'($urandom_range(0, 32'h00FF_FFFF));
            default: return 32'($urandom_range(32'h007F_FF00, 32'h0080_00FF));
        endcase
    endfunction

    initial begin
        bit s, ok;
        idle_inputs();
        reset = 1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("rst");
        reset = 0;
        @(posedge clock); #1;
        chk("idle_ready", 32'(in_ready), 0);

        for (int i = 0; i < 8; i++) begin fdata[i] = 32'h100 * (i + 1); frelu[i] = 0; end
        run_frame(0, 0);

        fdata = '{32'h0001_2345, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'h0000_00FF,
                  32'hFFFF_FFFF, 32'h007F_FFFF, 32'hFF80_0000, 32'hFFFF_FE80};
        frelu = '{0, 0, 1, 0, 0, 0, 0, 1};
        run_frame(0, 0);

        fdata = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0080_0000, 32'hFF7F_FFFF,
                  32'h8000_0000, 32'h0000_0300, 32'hFFFF_FD00, 32'h0000_0000};
        frelu = '{0, 0, 0, 0, 1, 0, 0, 0};
        run_frame(0, 0);

        for (int i = 0; i < 8; i++) begin fdata[i] = rand_acc(); frelu[i] = 1'($urandom_range(0, 1)); end
        run_frame(1, 0);
        for (int i = 0; i < 8; i++) begin fdata[i] = rand_acc(); frelu[i] = 1'($urandom_range(0, 1)); end
        run_frame(0, 1);

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 8; i++) begin fdata[i] = rand_acc(); frelu[i] = 1'($urandom_range(0, 1)); end
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // reset with a write pending and a fourth word offered
        start = 1; @(posedge clock); #1; start = 0;
        for (int i = 0; i < 3; i++) begin
            send_word(32'h7FFF_0000 - 32'(i), 0, i, 0, s, ok);
            if (!ok) break;
        end
        in_data = 32'h0000_0400; in_valid = 1; reset = 1; start = 1;
        @(posedge clock); #1;
        check_reset_values("midrst");
        reset = 0; start = 0; in_valid = 0;
        @(posedge clock); #1;
        chk("midrst_idle_en", 32'(ram_enable), 0);
        chk("midrst_idle_state", 32'(dbg_state), 0);

        for (int i = 0; i < 8; i++) begin fdata[i] = rand_acc(); frelu[i] = 1'($urandom_range(0, 1)); end
        run_frame(0, 0);

        repeat (3) @(posedge clock);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/output_writer.md
# output_writer

Post-processing and write-back stage feeding the 8-entry, 16-bit output RAM. Accepts a frame of wide accumulator results over a valid/ready stream and rescales each value to Q8.8 with an arithmetic shift. Applies optional ReLU and signed saturation, then writes the results to RAM addresses 0..7 in arrival order. Signals frame completion to the layer controller.

## Interface

- ACC_WIDTH, 32, input accumulator width, signed, Q(ACC_WIDTH-2·FRAC_BITS).(2·FRAC_BITS)
- DATA_WIDTH, 16, RAM word width, signed Q8.8
- FRAC_BITS, 8, right-shift amount applied to accumulator
- DEPTH, 8, words per frame (= RAM depth)
- ADDR_WIDTH, 3, RAM address width (log2 DEPTH)

Ports:

- clock  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  begin a frame; honoured only in IDLE
- relu_en  in  1  sampled with each accepted word; 1 = clamp negatives to 0
- in_valid  in  1  in_data valid
- in_ready  out  1  block can take a word this cycle
- in_data  in  ACC_WIDTH  signed accumulator value
- ram_address  out  ADDR_WIDTH  RAM write address
- ram_write_data  out  DATA_WIDTH  RAM write data
- ram_enable  out  1  RAM enable
- ram_write  out  1  RAM write strobe (always equal to ram_enable)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse coincident with the final write of a frame
- sat_flag  out  1  sticky: any word of current frame saturated; cleared on start

## Operation

- States: IDLE, RUN, DONE.
- IDLE → RUN on start; word count cleared to 0; sat_flag cleared.
- RUN: in_ready = 1 while count < DEPTH. Accept on in_valid & in_ready; count += 1.
- RUN → DONE on the edge that accepts word DEPTH-1.
- DONE → IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE. in_ready = 0 in IDLE and DONE.
- Datapath per accepted word:
  - s = in_data >>> FRAC_BITS (arithmetic shift, floor).
  - If relu_en and s < 0, s = 0.
  - Saturate s to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. sat_flag sets if clamping occurred; the ReLU clamp does not count.
- The result is registered into the write stage with ram_address = count at acceptance. ram_enable and ram_write are high for exactly one cycle per accepted word.
- Addresses run 0..DEPTH-1 with no wrap inside a frame. Each frame restarts at 0.
- No backpressure from RAM; a write never stalls.
- in_valid while in_ready = 0: the word is not consumed. Upstream must hold it.

## Timing

- Reset values: in_ready 0, ram_enable 0, ram_write 0, ram_address 0, ram_write_data 0, busy 0, done 0, sat_flag 0, state IDLE, count 0.
- start high at edge E: busy and in_ready are high in the cycle after E.
- Word accepted at edge A: RAM write is presented in cycle A+1 (latency 1) and committed by RAM at edge A+1.
- The final word accepted at edge L: cycle L+1 has done = 1, ram_write = 1, ram_address = DEPTH-1, and state DONE. Cycle L+2 is IDLE with busy = 0.
- Back-to-back: start in cycle L+2 is honoured. Minimum frame period is DEPTH + 2 cycles with in_valid held high.
- Reset asserted mid-frame: at the next edge all outputs return to reset values. Any pending write is dropped, so ram_enable = 0 in the following cycle.
- reset and start together: reset wins.

## Test plan

- Reset, then start, then 8 consecutive words 0x00000100·(i+1), relu_en = 0. Required: RAM addresses 0..7 receive 0x0001..0x0008, one per cycle, starting 1 cycle after first acceptance. done pulses with address 7. busy drops the next cycle. sat_flag = 0.
- Rounding and sign: 0x00012345 → 0x0123; 0xFFFFFF00 → 0xFFFF with relu_en = 0 and 0x0000 with relu_en = 1. sat_flag stays 0.
- Saturation: 0x7FFFFFFF → 0x7FFF; 0x80000000 → 0x8000. sat_flag is set and stays set until the next start, which clears it.
- Throttled stream: toggle in_valid 1,0,0,1,… Required: writes occur only 1 cycle after each handshake, with addresses contiguous 0..7. in_ready stays 0 after the 8th acceptance even if in_valid remains high.
- start pulses during RUN and in the DONE cycle are ignored: count, addresses and done timing are unchanged. start in the cycle after DONE begins a new frame at address 0.
- Reset asserted after 3 accepted words while a write is pending: the next cycle has ram_enable = 0, all outputs at reset values, and IDLE. A new start writes from address 0.
